alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, number of buffer entries (2 or 4 only).
REQ-002 The block SHALL have port clkout input 1: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset input 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid input 1: the ALU stage presents a completed operation.
REQ-005 The block SHALL have port in_ready output 1: the buffer can accept this cycle.
REQ-006 The block SHALL have port result input 32: ALU result.
REQ-007 The block SHALL have port flags input 5: ALU flags, where bit0=carry, bit1=zero, bit2=negative, bit3=overflow and bit4=parity.
REQ-008 The block SHALL have port opcode input 8: opcode of the completed operation.
REQ-009 The block SHALL have port dest input 4: destination register index.
REQ-010 The block SHALL have port rf_ready input 1: the register-file write port is free.
REQ-011 The block SHALL have port rf_we output 1: register-file write strobe.
REQ-012 The block SHALL have port rf_waddr output 4: write address.
REQ-013 The block SHALL have port rf_wdata output 32: write data.
REQ-014 The block SHALL have port flag_reg output 5: architectural flag register.
REQ-015 The block SHALL have port cin output 1: carry feedback to the ALU, equal to flag_reg[0].
REQ-016 The block SHALL have port retired output 16: count of retired entries.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready; {result, flags, opcode, dest} is written at the write pointer.
REQ-018 in_ready SHALL be 1 when occupancy < DEPTH, and also when full && a retire occurs in the same cycle.
REQ-019 The buffer SHALL be FIFO, with read/write pointers wrapping modulo DEPTH and a separate occupancy counter of width clog2(DEPTH)+1.
REQ-020 Retire SHALL occur when occupancy > 0 && (rf_ready || head entry needs no register write); exactly one entry retires per cycle, in order.
REQ-021 Class W+F (opcode 1..31) SHALL, at retire, assert rf_we and update flag_reg <= head flags.
REQ-022 Class W (opcode 32 POP, 34 MVS, 42 MVP, 47 MVR) SHALL, at retire, assert rf_we and leave flag_reg unchanged.
REQ-023 Class D (all other opcodes, including 0, 53 NOP, and 54..255) SHALL retire without rf_ready, without rf_we, and without a flag change.
REQ-024 rf_we, rf_waddr and rf_wdata SHALL be combinational from the head entry and SHALL be qualified by the retire condition; rf_we SHALL be 0 when empty.
REQ-025 flag_reg SHALL update on the clock edge ending the retire cycle, so a following ALU op sees the new cin one cycle after retire.
REQ-026 retired SHALL increment by 1 per retire of any class and SHALL wrap 16'hFFFF -> 0.
REQ-027 A simultaneous accept and retire SHALL leave occupancy unchanged, and both pointers SHALL advance.
REQ-028 An accept into an empty buffer SHALL NOT retire in the same cycle; minimum latency is accept at edge N, rf_we high during cycle N+1.
REQ-029 A Class W+F head blocked by rf_ready=0 SHALL stall all later entries, including Class D entries.
REQ-030 An in_valid=1 while in_ready=0 SHALL NOT be captured, and the upstream stage SHALL hold its inputs.

Reset
REQ-031 When reset=1 at an edge, occupancy, both pointers, flag_reg and retired SHALL be set to 0.
REQ-032 Reset SHALL take priority over a concurrent accept or retire, and buffered entries SHALL be discarded without a write.
REQ-033 During the cycle after reset, in_ready SHALL be 1, rf_we SHALL be 0 and cin SHALL be 0.
REQ-034 Buffer data storage SHALL need no reset.

Verification
REQ-035 Scenario: accept ADD (1), result=32'h68A7CEE1, flags=5'b00001, dest=3, with rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=32'h68A7CEE1; flag_reg=5'b00001 and cin=1 after that edge; retired=1.
REQ-036 Scenario: rf_ready=0, accept three W+F ops with DEPTH=2 -> in_ready=0 after two accepts and the third is not captured; raise rf_ready -> two writes in order on consecutive cycles.
REQ-037 Scenario: accept NOP (53) then MVR (47), dest=5, with rf_ready=0 -> NOP retires (retired+1, no rf_we) and MVR waits; raise rf_ready -> write to reg 5 with flag_reg unchanged.
REQ-038 Scenario: full buffer with continuous in_valid and rf_ready=1 -> one accept and one retire per cycle, occupancy constant, pointers wrap correctly over 10 ops.
REQ-039 Scenario: reset asserted with 2 entries buffered -> no rf_we during or after reset, flag_reg=0, retired=0, in_ready=1.
REQ-040 Scenario: preload retired=16'hFFFF via 65535 Class D ops, then one more op -> retired=0.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU writeback buffer: in-order FIFO of completed ALU operations that retires
// one entry per cycle into the register file and the architectural flag register.
module alu_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clkout,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [4:0]  flags,
  input  logic [7:0]  opcode,
  input  logic [3:0]  dest,
  input  logic        rf_ready,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  flag_reg,
  output logic        cin,
  output logic [15:0] retired
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    CLS_DISCARD,
    CLS_WRITE,
    CLS_WRITE_FLAGS
  } op_class_e;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [7:0]  op;
    logic [3:0]  dst;
  } entry_t;

  function automatic op_class_e classify(input logic [7:0] op);
    op_class_e cls;
    cls = CLS_DISCARD;
    if (op >= 8'd1 && op <= 8'd31) begin
      cls = CLS_WRITE_FLAGS;
    end else if (op == 8'd32 || op == 8'd34 || op == 8'd42 || op == 8'd47) begin
      cls = CLS_WRITE;
    end
    return cls;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [4:0]       flag_reg_q, flag_reg_d;
  logic [15:0]      retired_q, retired_d;

  entry_t    head;
  op_class_e head_cls;
  logic      retire;
  logic      accept;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    head_cls = classify(head.op);
    // Reset suppresses retirement so buffered entries are dropped without a write.
    retire   = !reset && (occ_q != '0) && (rf_ready || head_cls == CLS_DISCARD);
    in_ready = (occ_q < CNT_W'(DEPTH)) || retire;
    accept   = in_valid && in_ready;
    rf_we    = retire && (head_cls != CLS_DISCARD);
    rf_waddr = rf_we ? head.dst : '0;
    rf_wdata = rf_we ? head.res : '0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    flag_reg_d = flag_reg_q;
    retired_d  = retired_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (retire) begin
      rd_ptr_d  = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      retired_d = retired_q + 16'd1;
      if (head_cls == CLS_WRITE_FLAGS) begin
        flag_reg_d = head.fl;
      end
    end
    if (accept && !retire) begin
      occ_d = occ_q + 1'b1;
    end else if (retire && !accept) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clkout) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      flag_reg_q <= '0;
      retired_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      flag_reg_q <= flag_reg_d;
      retired_q  <= retired_d;
    end
  end

  always_ff @(posedge clkout) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= '{res: result, fl: flags, op: opcode, dst: dest};
    end
  end

  assign flag_reg = flag_reg_q;
  assign cin      = flag_reg_q[0];
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the writeback buffer.
module tb_alu_writeback;

  localparam int DEPTH = 2;

  logic        clkout = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic [4:0]  flags;
  logic [7:0]  opcode;
  logic [3:0]  dest;
  logic        rf_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  flag_reg;
  logic        cin;
  logic [15:0] retired;

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clkout   (clkout),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .flags    (flags),
    .opcode   (opcode),
    .dest     (dest),
    .rf_ready (rf_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .flag_reg (flag_reg),
    .cin      (cin),
    .retired  (retired)
  );

  always #5 clkout = ~clkout;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [7:0]  op;
    logic [3:0]  dst;
  } entry_t;

  entry_t      mq[$];
  logic [4:0]  m_flag;
  logic [15:0] m_ret;
  bit          last_acc;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic bit writes_rf(input logic [7:0] op);
    return (op >= 1 && op <= 31) || op == 32 || op == 34 || op == 42 || op == 47;
  endfunction

  function automatic bit writes_flags(input logic [7:0] op);
    return op >= 1 && op <= 31;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at a negedge; check combinational outputs, advance one edge,
  // update the model, then check registered outputs at the next negedge.
  task automatic step();
    bit     exp_ret, exp_rdy, exp_we;
    entry_t h;
    #1;
    exp_ret = !reset && mq.size() > 0 && (rf_ready || !writes_rf(mq[0].op));
    exp_rdy = mq.size() < DEPTH || exp_ret;
    exp_we  = exp_ret && writes_rf(mq[0].op);
    chk("in_ready", in_ready, exp_rdy);
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, mq[0].dst);
      chk("rf_wdata", rf_wdata, mq[0].res);
    end
    chk("cin", cin, m_flag[0]);
    @(posedge clkout);
    last_acc = 1'b0;
    if (reset) begin
      mq.delete();
      m_flag = '0;
      m_ret  = '0;
    end else begin
      if (exp_ret) begin
        h = mq.pop_front();
        if (writes_flags(h.op)) m_flag = h.fl;
        m_ret = m_ret + 16'd1;
      end
      if (in_valid && exp_rdy) begin
        mq.push_back(entry_t'({result, flags, opcode, dest}));
        last_acc = 1'b1;
      end
    end
    @(negedge clkout);
    chk("flag_reg", flag_reg, m_flag);
    chk("retired", retired, m_ret);
  endtask

  task automatic offer(input logic [7:0] op, input logic [31:0] res,
                       input logic [4:0] fl, input logic [3:0] dst);
    in_valid = 1'b1;
    opcode   = op;
    result   = res;
    flags    = fl;
    dest     = dst;
  endtask

  task automatic rand_op();
    logic [7:0] wlist [4];
    wlist = '{8'd32, 8'd34, 8'd42, 8'd47};
    case ($urandom_range(0, 2))
      0: opcode = 8'($urandom_range(1, 31));
      1: opcode = wlist[$urandom_range(0, 3)];
      default: begin
        case ($urandom_range(0, 3))
          0: opcode = 8'd0;
          1: opcode = 8'd53;
          2: opcode = 8'($urandom_range(54, 255));
          default: opcode = 8'd33;
        endcase
      end
    endcase
    result = $urandom;
    flags  = 5'($urandom);
    dest   = 4'($urandom);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rf_ready = 1'b0;
    result = '0; flags = '0; opcode = '0; dest = '0;
    @(negedge clkout);
    @(negedge clkout);
    reset = 1'b0;
    mq.delete(); m_flag = '0; m_ret = '0;
    #1;
    chk("post_reset_in_ready", in_ready, 1'b1);
    chk("post_reset_rf_we", rf_we, 1'b0);
    chk("post_reset_cin", cin, 1'b0);
    chk("post_reset_retired", retired, 16'd0);

    // Single ADD, minimum latency and carry feedback
    rf_ready = 1'b1;
    offer(8'd1, 32'h68A7CEE1, 5'b00001, 4'd3);
    step();
    in_valid = 1'b0;
    #1;
    chk("add_rf_we", rf_we, 1'b1);
    chk("add_waddr", rf_waddr, 4'd3);
    chk("add_wdata", rf_wdata, 32'h68A7CEE1);
    step();
    chk("add_flag_reg", flag_reg, 5'b00001);
    chk("add_cin", cin, 1'b1);
    chk("add_retired", retired, 16'd1);

    // Backpressure: third op refused while full, then in-order drain
    rf_ready = 1'b0;
    offer(8'd2, 32'hAAAA0001, 5'b00010, 4'd1); step();
    offer(8'd3, 32'hAAAA0002, 5'b00100, 4'd2); step();
    offer(8'd4, 32'hAAAA0003, 5'b01000, 4'd4);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    rf_ready = 1'b1;
    #1;
    chk("drain0_waddr", rf_waddr, 4'd1);
    step();
    #1;
    chk("drain1_waddr", rf_waddr, 4'd2);
    chk("drain1_wdata", rf_wdata, 32'hAAAA0002);
    step();
    #1;
    chk("drain_empty_we", rf_we, 1'b0);
    step();
    chk("drain_retired", retired, 16'd3);
    chk("drain_flag_reg", flag_reg, 5'b00100);

    // NOP retires past a stalled register file; MVR then writes without flag change
    rf_ready = 1'b0;
    offer(8'd53, 32'h0, 5'b11111, 4'd0); step();
    offer(8'd47, 32'h5555AAAA, 5'b11111, 4'd5); step();
    in_valid = 1'b0;
    step();
    chk("nop_retired", retired, 16'd4);
    rf_ready = 1'b1;
    #1;
    chk("mvr_waddr", rf_waddr, 4'd5);
    step();
    chk("mvr_flag_reg", flag_reg, 5'b00100);

    // Fill, then stream 10 ops with one accept and one retire per cycle
    rf_ready = 1'b0;
    offer(8'd32, 32'h100, 5'd0, 4'd6); step();
    offer(8'd34, 32'h101, 5'd0, 4'd7); step();
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(8'(5 + i), 32'h200 + 32'(i), 5'(i), 4'(i));
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;

    // Reset with two entries buffered
    rf_ready = 1'b0;
    offer(8'd9, 32'h300, 5'd3, 4'd8); step();
    offer(8'd10, 32'h301, 5'd5, 4'd9); step();
    reset = 1'b1; rf_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_cin", cin, 1'b0);
    chk("rst_flag_reg", flag_reg, 5'd0);
    chk("rst_retired", retired, 16'd0);
    step();

    // Random traffic; upstream holds a refused offer
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = 1'($urandom);
        rand_op();
      end
      rf_ready = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    // Counter wrap through 65535 Class D retirements
    reset = 1'b1; in_valid = 1'b0; step(); reset = 1'b0;
    for (int i = 0; i < 70000 && m_ret != 16'hFFFF; i++) begin
      in_valid = (int'(m_ret) + mq.size() < 65535);
      opcode   = 8'($urandom_range(54, 255));
      result   = $urandom;
      flags    = 5'($urandom);
      dest     = 4'($urandom);
      rf_ready = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_preload", retired, 16'hFFFF);
    offer(8'd0, 32'h0, 5'd0, 4'd0); step();
    in_valid = 1'b0;
    step();
    chk("wrap_zero", retired, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
